ogr_mark_counter_assembly: RTL and testbench

Hardware backtracking search for optimal Golomb rulers (OGR) with NUM_POSITIONS+1 marks. It starts from a host-supplied preset ruler and tests one candidate per clock. It keeps the shortest valid rulers found so far and raises `done` when the search space is exhausted. It is the top-level search core behind the host/FPGA interface; the clock comes from an external clock generator.

---
 rtl/ogr_mark_counter_assembly.sv | 182 ++++++++++++++++++
 tb/tb_ogr_mark_counter_assembly.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ogr_mark_counter_assembly.sv
// Backtracking search for optimal Golomb rulers: one candidate per clock, keeps the shortest rulers seen.
// Define WITH_RESULTS_ARRAY_EN to add result-slot storage and the `results` port.
module ogr_mark_counter_assembly #(
  parameter int NUM_POSITIONS = 5,
  parameter int POS_WIDTH     = 8,
  parameter int FIRST_FREE    = 2,
  parameter int NUM_RESULTS   = 5
) (
  input  logic                                                FXCLK,
  input  logic                                                RESET_IN,
  input  logic [(NUM_POSITIONS+1)*POS_WIDTH-1:0]              firstvalues,
  output logic [(NUM_POSITIONS+1)*POS_WIDTH-1:0]              marks,
`ifdef WITH_RESULTS_ARRAY_EN
  output logic [NUM_RESULTS*(NUM_POSITIONS+1)*POS_WIDTH-1:0]  results,
`endif
  output logic [5:0]                                          numResultsObserved,
  output logic                                                done
);
  localparam int N  = NUM_POSITIONS;
  localparam int W  = POS_WIDTH;
  localparam int RW = (N + 1) * W;
  localparam int EW = W + 4;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] m_q [0:N];
  logic [W-1:0] m_d [0:N];
  logic [W-1:0] best_q, best_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         done_q, done_d;

  logic [N:0]   inc_s, dup_s, invalid_s, fit_s;
  logic         golomb_s, adv_ok_s;
  int           p_s, q_s;
  logic [W-1:0] base_s;

  function automatic logic [W-1:0] diff_f(input logic [W-1:0] hi, input logic [W-1:0] lo);
    return hi - lo;
  endfunction

  // Prefix validity: a prefix goes bad at the first index that breaks ordering or repeats a difference.
  always_comb begin
    inc_s    = '0;
    dup_s    = '0;
    inc_s[0] = 1'b1;
    for (int b = 1; b <= N; b++) begin
      inc_s[b] = inc_s[b-1] & (m_q[b] > m_q[b-1]);
      dup_s[b] = dup_s[b-1];
      for (int a = 0; a < b; a++)
        for (int d = 1; d <= b; d++)
          for (int c = 0; c < d; c++)
            dup_s[b] = dup_s[b] | (((d < b) || (c < a)) &&
                                   (diff_f(m_q[b], m_q[a]) == diff_f(m_q[d], m_q[c])));
    end
    invalid_s = ~inc_s | dup_s;
    golomb_s  = ~invalid_s[N];
    p_s       = N;
    for (int k = N; k >= 0; k--)
      p_s = invalid_s[k] ? ((k < FIRST_FREE) ? FIRST_FREE : k) : p_s;
  end

  // Advance point: deepest index <= p whose minimal tail still fits under the pre-update best.
  always_comb begin
    fit_s    = '0;
    q_s      = 0;
    adv_ok_s = 1'b0;
    base_s   = '0;
    for (int q = FIRST_FREE; q <= N; q++)
      fit_s[q] = (q <= p_s) && (({4'b0000, m_q[q]} + EW'(N - q + 1)) <= {4'b0000, best_q});
    for (int q = FIRST_FREE; q <= N; q++) begin
      q_s      = fit_s[q] ? q : q_s;
      adv_ok_s = adv_ok_s | fit_s[q];
    end
    for (int q = 0; q <= N; q++)
      base_s = (q == q_s) ? (m_q[q] + W'(1)) : base_s;
  end

  // Next-state: load preset, evaluate/advance one candidate per cycle, then freeze.
  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    for (int i = 0; i <= N; i++) m_d[i] = m_q[i];
    case (state_q)
      ST_LOAD: begin
        for (int i = 0; i <= N; i++) m_d[i] = firstvalues[(N-i)*W +: W];
        best_d  = '1;
        state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (golomb_s && (m_q[N] < best_q)) begin
          best_d = m_q[N];
          cnt_d  = 6'd1;
        end else if (golomb_s && (m_q[N] == best_q)) begin
          cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
        end else begin
          cnt_d = cnt_q;
        end
        if (adv_ok_s) begin
          for (int j = 0; j <= N; j++)
            m_d[j] = (j > q_s) ? (base_s + W'(j - q_s)) : ((j == q_s) ? base_s : m_q[j]);
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_LOAD;
        done_d  = 1'b0;
      end
    endcase
  end

  // Search state registers.
  always_ff @(posedge FXCLK or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q <= ST_LOAD;
      best_q  <= '1;
      cnt_q   <= 6'd0;
      done_q  <= 1'b0;
      for (int i = 0; i <= N; i++) m_q[i] <= '0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      for (int i = 0; i <= N; i++) m_q[i] <= m_d[i];
    end
  end

  for (genvar g = 0; g <= N; g++) begin : g_marks
    assign marks[(N-g)*W +: W] = m_q[g];
  end
  assign numResultsObserved = cnt_q;
  assign done               = done_q;

`ifdef WITH_RESULTS_ARRAY_EN
  localparam logic [5:0] NRES6 = 6'(NUM_RESULTS);
  logic [RW-1:0] res_q [1:NUM_RESULTS];
  logic          rec_s;
  logic [5:0]    rec_slot_s;

  // Record slot for the ruler seen this cycle, if any.
  always_comb begin
    rec_s      = 1'b0;
    rec_slot_s = 6'd0;
    if ((state_q == ST_SEARCH) && golomb_s && (m_q[N] < best_q)) begin
      rec_s      = 1'b1;
      rec_slot_s = 6'd1;
    end else if ((state_q == ST_SEARCH) && golomb_s && (m_q[N] == best_q) && (cnt_d <= NRES6)) begin
      rec_s      = 1'b1;
      rec_slot_s = cnt_d;
    end else begin
      rec_s      = 1'b0;
    end
  end

  // Result slots hold the candidate as it was when recorded.
  always_ff @(posedge FXCLK or negedge RESET_IN) begin
    if (!RESET_IN) begin
      for (int s = 1; s <= NUM_RESULTS; s++) res_q[s] <= '0;
    end else begin
      for (int s = 1; s <= NUM_RESULTS; s++)
        if (rec_s && (rec_slot_s == 6'(s))) res_q[s] <= marks;
    end
  end

  for (genvar s = 1; s <= NUM_RESULTS; s++) begin : g_results
    assign results[(NUM_RESULTS-s)*RW +: RW] = res_q[s];
  end
`endif
endmodule

// File: tb/tb_ogr_mark_counter_assembly.sv
// Scoreboard bench for ogr_mark_counter_assembly: a behavioural search model predicts every edge.
module tb_ogr_mark_counter_assembly;
  localparam int NP = 5;
  localparam int W  = 8;
  localparam int FF = 2;
  localparam int NR = 5;
  localparam int RW = (NP + 1) * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] fv, marks_o;
  logic [5:0]    cnt_o;
  logic          done_o;
  logic [31:0]   fv3, marks3;
  logic [5:0]    cnt3;
  logic          done3;
`ifdef WITH_RESULTS_ARRAY_EN
  logic [NR*RW-1:0] res_o;
  logic [NR*32-1:0] res3;
`endif

  always #5 clk = ~clk;

  ogr_mark_counter_assembly u_dut (
    .FXCLK(clk), .RESET_IN(rst_n), .firstvalues(fv), .marks(marks_o),
`ifdef WITH_RESULTS_ARRAY_EN
    .results(res_o),
`endif
    .numResultsObserved(cnt_o), .done(done_o)
  );

  ogr_mark_counter_assembly #(.NUM_POSITIONS(3)) u_dut3 (
    .FXCLK(clk), .RESET_IN(rst_n), .firstvalues(fv3), .marks(marks3),
`ifdef WITH_RESULTS_ARRAY_EN
    .results(res3),
`endif
    .numResultsObserved(cnt3), .done(done3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model state
  int            pre [0:NP];
  int            mm  [0:NP];
  int            mbest, mcnt, ms;
  bit            mdone;
  logic [RW-1:0] mslot [1:NR];
  logic [63:0]   sb_q [$];
  int            cyc, done_cyc;

  function automatic logic [RW-1:0] pack_marks();
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i <= NP; i++) r[(NP-i)*W +: W] = W'(mm[i]);
    return r;
  endfunction

  // Smallest k >= FF whose prefix is invalid, or -1 for a complete ruler.
  function automatic int first_bad();
    bit seen [0:255];
    bit bad;
    int d;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int k = 1; k <= NP; k++) begin
      bad = (mm[k] <= mm[k-1]);
      if (!bad) begin
        for (int i = 0; i < k; i++) begin
          d = mm[k] - mm[i];
          if (seen[d]) bad = 1'b1;
          seen[d] = 1'b1;
        end
      end
      if (bad) return (k < FF) ? FF : k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ms = 0; mdone = 1'b0; mcnt = 0; mbest = 255;
    for (int i = 0; i <= NP; i++) mm[i] = 0;
    for (int s = 1; s <= NR; s++) mslot[s] = '0;
  endtask

  task automatic model_step();
    int k, p, q, ob, v;
    bit ok;
    if (ms == 0) begin
      for (int i = 0; i <= NP; i++) mm[i] = pre[i];
      mbest = 255;
      ms = 1;
    end else if (ms == 1) begin
      ob = mbest;
      k  = first_bad();
      p  = (k < 0) ? NP : k;
      if (k < 0 && mm[NP] < mbest) begin
        mbest = mm[NP]; mcnt = 1; mslot[1] = pack_marks();
      end else if (k < 0 && mm[NP] == mbest) begin
        if (mcnt < 63) mcnt++;
        if (mcnt <= NR) mslot[mcnt] = pack_marks();
      end
      ok = 1'b0; q = p;
      while (!ok && q >= FF) begin
        if (mm[q] + 1 + (NP - q) <= ob) ok = 1'b1;
        else q--;
      end
      if (ok) begin
        v = mm[q] + 1;
        for (int j = q; j <= NP; j++) mm[j] = v + (j - q);
      end else begin
        ms = 2; mdone = 1'b1;
      end
    end
  endtask

  task automatic one_cycle();
    model_step();
    sb_q.push_back({9'd0, mdone, 6'(mcnt), pack_marks()});
    @(posedge clk); #1;
    cyc++;
    check_eq("cycle", {9'd0, done_o, cnt_o, marks_o}, sb_q.pop_front());
    if (done_o && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic run_to_done(input int budget);
    int post = 0;
    int n = 0;
    while (post < 3 && n < budget) begin
      one_cycle();
      n++;
      if (mdone) post++;
    end
    check_eq("done_reached", 64'(done_o), 64'd1);
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_marks"}, 64'(marks_o), 64'd0);
    check_eq({pfx, "_count"}, 64'(cnt_o), 64'd0);
    check_eq({pfx, "_done"}, 64'(done_o), 64'd0);
`ifdef WITH_RESULTS_ARRAY_EN
    check_eq({pfx, "_results_or"}, 64'(|res_o), 64'd0);
`endif
  endtask

  logic [RW-1:0] exp_slots [1:4];

  task automatic final_checks(input string pfx);
    check_eq({pfx, "_count"}, 64'(cnt_o), 64'd4);
`ifdef WITH_RESULTS_ARRAY_EN
    for (int s = 1; s <= 4; s++)
      check_eq($sformatf("%s_slot%0d", pfx, s), 64'(res_o[(NR-s)*RW +: RW]), 64'(exp_slots[s]));
    check_eq({pfx, "_slot5"}, 64'(res_o[0 +: RW]), 64'(mslot[5]));
    check_eq({pfx, "_best_len"}, 64'(res_o[(NR-1)*RW +: W]), 64'd17);
`endif
  endtask

  initial begin
    logic [RW-1:0] adv_exp;
    int dc1, mid;
    exp_slots[1] = {8'd0, 8'd1, 8'd4, 8'd10, 8'd12, 8'd17};
    exp_slots[2] = {8'd0, 8'd1, 8'd4, 8'd10, 8'd15, 8'd17};
    exp_slots[3] = {8'd0, 8'd1, 8'd8, 8'd11, 8'd13, 8'd17};
    exp_slots[4] = {8'd0, 8'd1, 8'd8, 8'd12, 8'd14, 8'd17};
    adv_exp      = {8'd0, 8'd1, 8'd3, 8'd4, 8'd5, 8'd6};
    rst_n = 1'b0;
    fv    = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    fv3   = {8'd0, 8'd1, 8'd2, 8'd3};
    for (int i = 0; i <= NP; i++) pre[i] = i;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");

    // Uninterrupted run
    @(negedge clk); rst_n = 1'b1;
    cyc = 0; done_cyc = -1;
    one_cycle();
    check_eq("load_marks", 64'(marks_o), 64'(fv));
    one_cycle();
    check_eq("first_adv", 64'(marks_o), 64'(adv_exp));
    run_to_done(40000);
    final_checks("run1");
    dc1 = done_cyc;

    // Restart after aborting mid-search
    mid = (dc1 > 8) ? dc1 / 2 : 4;
    @(negedge clk); rst_n = 1'b0;
    #1; check_reset_vals("rst2");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    cyc = 0; done_cyc = -1;
    repeat (mid) one_cycle();
    #2; rst_n = 1'b0;
    #1; check_reset_vals("abort");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    cyc = 0; done_cyc = -1;
    run_to_done(40000);
    final_checks("run2");
    check_eq("restart_done_cycle", 64'(done_cyc), 64'(dc1));

    // Four-mark instance
    for (int i = 0; i < 4000 && !done3; i++) @(posedge clk);
    #1;
    check_eq("np3_done", 64'(done3), 64'd1);
    check_eq("np3_count", 64'(cnt3), 64'd1);
`ifdef WITH_RESULTS_ARRAY_EN
    check_eq("np3_slot1", 64'(res3[4*32 +: 32]), 64'({8'd0, 8'd1, 8'd4, 8'd6}));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
